// File: rtl/heq_pkg.sv
// Shared types and constants for the histogram-equalisation divider path.
// Imported by the sequencer and by the divider wrapper.
package heq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    SETUP,
    RUN,
    WR,
    DONE
  } state_t;

  // CDF entries below this floor skip the divider and map to zero.
  localparam logic [7:0] CDFMIN  = 8'd1;
  localparam logic [7:0] LUT_SAT = 8'hFF;

endpackage

// File: rtl/heq_div_sequencer.sv
// Walks every CDF bin: read CDF entry, run the divider (or bypass it),
// and write the resulting quotient into the equalisation LUT.
module heq_div_sequencer
  import heq_pkg::*;
#(
  parameter int NBINS   = 256,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              cdf_rd_en,
  output logic [ADDR_W-1:0] cdf_rd_addr,
  input  logic [7:0]        cdf_rd_data,
  output logic [7:0]        div_cdf_in,
  output logic              div_en,
  input  logic [7:0]        div_g_out,
  input  logic              div_ready,
  output logic              lut_wr_en,
  output logic [ADDR_W-1:0] lut_wr_addr,
  output logic [7:0]        lut_wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [ADDR_W:0] LAST_BIN = (ADDR_W + 1)'(NBINS - 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic [ADDR_W:0]   bin, bin_nx;          // one spare bit so NBINS == 2**ADDR_W ends cleanly
  logic [WD_W-1:0]   wd, wd_nx;
  logic [7:0]        operand, operand_nx;
  logic [7:0]        wr_data, wr_data_nx;
  logic              err_q, err_nx;

  // NOTE: reset is sampled on the clock edge only; state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      bin     <= '0;
      wd      <= '0;
      operand <= '0;
      wr_data <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      bin     <= bin_nx;
      wd      <= wd_nx;
      operand <= operand_nx;
      wr_data <= wr_data_nx;
      err_q   <= err_nx;
    end
  end

  // NOTE: every next-state signal holds its current value by default so no latch is inferred.
  always_comb begin
    state_nx   = state;
    bin_nx     = bin;
    wd_nx      = wd;
    operand_nx = operand;
    wr_data_nx = wr_data;
    err_nx     = err_q;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = RD;
          bin_nx   = '0;
          err_nx   = 1'b0;
        end
      end
      RD: state_nx = CAP;
      CAP: begin
        operand_nx = cdf_rd_data;
        if (cdf_rd_data < CDFMIN) begin
          wr_data_nx = '0;
          state_nx   = WR;
        end else begin
          state_nx = SETUP;
        end
      end
      SETUP: begin
        wd_nx    = '0;
        state_nx = RUN;
      end
      RUN: begin
        // A ready on the terminal watchdog count still wins over the timeout.
        if (div_ready) begin
          wr_data_nx = div_g_out;
          state_nx   = WR;
        end else if (wd == WD_LAST) begin
          wr_data_nx = LUT_SAT;
          err_nx     = 1'b1;
          state_nx   = WR;
        end else begin
          wd_nx = wd + 1'b1;
        end
      end
      WR: begin
        if (bin == LAST_BIN) begin
          state_nx = DONE;
        end else begin
          bin_nx   = bin + 1'b1;
          state_nx = RD;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign cdf_rd_en   = (state == RD);
  assign cdf_rd_addr = bin[ADDR_W-1:0];
  assign div_cdf_in  = operand;
  assign div_en      = (state == RUN);
  assign lut_wr_en   = (state == WR);
  assign lut_wr_addr = bin[ADDR_W-1:0];
  assign lut_wr_data = wr_data;
  assign busy        = (state != IDLE) && (state != DONE);
  assign done        = (state == DONE);
  assign err         = err_q;

endmodule

// File: tb/tb_heq_div_sequencer.sv
// Self-checking bench: CDF RAM and divider models, LUT write monitor,
// and a per-bin reference of expected LUT contents and run length.
module tb_heq_div_sequencer;
  import heq_pkg::*;

  localparam int NB = 256;
  localparam int AW = 8;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          cdf_rd_en;
  logic [AW-1:0] cdf_rd_addr;
  logic [7:0]    cdf_rd_data = '0;
  logic [7:0]    div_cdf_in;
  logic          div_en;
  logic [7:0]    div_g_out;
  logic          div_ready;
  logic          lut_wr_en;
  logic [AW-1:0] lut_wr_addr;
  logic [7:0]    lut_wr_data;
  logic          busy;
  logic          done;
  logic          err;

  heq_div_sequencer #(.NBINS(NB), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cdf_rd_en(cdf_rd_en), .cdf_rd_addr(cdf_rd_addr), .cdf_rd_data(cdf_rd_data),
    .div_cdf_in(div_cdf_in), .div_en(div_en), .div_g_out(div_g_out), .div_ready(div_ready),
    .lut_wr_en(lut_wr_en), .lut_wr_addr(lut_wr_addr), .lut_wr_data(lut_wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Quotient produced by the divider model for a given operand.
  function automatic logic [7:0] qfun(input logic [7:0] c);
    return 8'((int'(c) * 3 + 7) ^ 8'h5A);
  endfunction

  logic [7:0] cdf_mem [NB];
  int         lat_tab [NB];   // ready after lat+1 cycles of div_en; >= TO means never
  bit         spurious = 1'b0;
  int         cur_bin = 0;
  int         dcnt = 0;
  int         cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cdf_rd_en) begin
      cdf_rd_data <= cdf_mem[cdf_rd_addr];
      cur_bin     <= int'(cdf_rd_addr);
    end
    dcnt <= div_en ? dcnt + 1 : 0;
  end

  assign div_ready = div_en ? (dcnt == lat_tab[cur_bin]) : spurious;
  assign div_g_out = qfun(div_cdf_in);

  int         wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  int         done_cnt, done_cyc, strobes;
  bit         busy_at_done, div_en_bin10, err_seen, err_dropped;

  always @(negedge clk) begin
    if (lut_wr_en) begin
      wr_addr_q.push_back(int'(lut_wr_addr));
      wr_data_q.push_back(lut_wr_data);
    end
    if (done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
    if (div_en && cur_bin == 10) div_en_bin10 = 1'b1;
    if (err) err_seen = 1'b1;
    else if (err_seen && busy) err_dropped = 1'b1;
    if (cdf_rd_en || lut_wr_en) strobes++;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int accept_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] ref_lut(input int b);
    if (cdf_mem[b] < CDFMIN) return 8'h00;
    if (lat_tab[b] >= TO)    return LUT_SAT;
    return qfun(cdf_mem[b]);
  endfunction

  function automatic int ref_cycles();
    int total = 0;
    for (int b = 0; b < NB; b++) begin
      if (cdf_mem[b] < CDFMIN)  total += 3;
      else if (lat_tab[b] >= TO) total += 4 + TO;
      else                      total += 5 + lat_tab[b];
    end
    return total;
  endfunction

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0; done_cyc = 0; strobes = 0;
    busy_at_done = 1'b0; div_en_bin10 = 1'b0; err_seen = 1'b0; err_dropped = 1'b0;
  endtask

  task automatic pulse_start(input bit record);
    @(negedge clk);
    start = 1'b1;
    if (record) accept_cyc = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 40000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cdf_rd_en"}, 32'(cdf_rd_en), 0);
    check({tag, "_cdf_rd_addr"}, 32'(cdf_rd_addr), 0);
    check({tag, "_div_cdf_in"}, 32'(div_cdf_in), 0);
    check({tag, "_div_en"}, 32'(div_en), 0);
    check({tag, "_lut_wr_en"}, 32'(lut_wr_en), 0);
    check({tag, "_lut_wr_addr"}, 32'(lut_wr_addr), 0);
    check({tag, "_lut_wr_data"}, 32'(lut_wr_data), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
  endtask

  task automatic check_run(input string tag);
    check({tag, "_wr_count"}, 32'(wr_addr_q.size()), 32'(NB));
    for (int b = 0; b < wr_addr_q.size() && b < NB; b++) begin
      check($sformatf("%s_addr%0d", tag, b), 32'(wr_addr_q[b]), 32'(b));
      check($sformatf("%s_lut%0d", tag, b), 32'(wr_data_q[b]), 32'(ref_lut(b)));
    end
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    check({tag, "_cycles"}, 32'(done_cyc - accept_cyc), 32'(ref_cycles()));
    check({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
  endtask

  task automatic fill(input int lo, input int lat_lo, input int lat_hi);
    for (int b = 0; b < NB; b++) begin
      cdf_mem[b] = 8'($urandom_range(lo, 255));
      lat_tab[b] = int'($urandom_range(lat_hi, lat_lo));
    end
  endtask

  initial begin
    clear_mon();
    fill(1, 3, 3);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle("reset");

    // Uniform 3-cycle divider, no bypass bins: exact 8 cycles per bin.
    clear_mon();
    pulse_start(1'b1);
    wait_done("t1");
    check_run("t1");
    check("t1_err", 32'(err), 0);

    // Bypass bins, random latencies, spurious ready outside RUN, second start mid-run.
    fill(0, 1, 6);
    for (int b = 0; b < NB; b++)
      if ($urandom_range(7, 0) == 0) cdf_mem[b] = 8'h00;
    cdf_mem[10] = 8'd0;
    cdf_mem[11] = 8'd1;
    spurious = 1'b1;
    clear_mon();
    pulse_start(1'b1);
    begin
      int n = 0;
      while (!(cdf_rd_en && cdf_rd_addr == 8'd100) && n < 5000) begin
        @(negedge clk);
        n++;
      end
      check("t2_reach_bin100", 32'(n < 5000), 32'd1);
    end
    pulse_start(1'b0);
    wait_done("t2");
    check_run("t2");
    check("t2_div_en_bin10", 32'(div_en_bin10), 0);
    check("t2_lut11", 32'(wr_data_q.size() > 11 ? wr_data_q[11] : 8'hxx), 32'(qfun(8'd1)));
    check("t2_err", 32'(err), 0);
    spurious = 1'b0;

    // Divider never answers on bin 5: saturated entry, sticky err, run continues.
    fill(1, 1, 4);
    lat_tab[5] = 1000;
    clear_mon();
    pulse_start(1'b1);
    wait_done("t3");
    check_run("t3");
    check("t3_lut5", 32'(wr_data_q.size() > 5 ? wr_data_q[5] : 8'hxx), 32'(LUT_SAT));
    check("t3_err_end", 32'(err), 1);
    check("t3_err_dropped", 32'(err_dropped), 0);
    repeat (5) @(negedge clk);
    check("t3_err_sticky", 32'(err), 1);

    // Ready on the watchdog terminal count of bin 7: quotient wins, err cleared by start.
    fill(1, 1, 4);
    lat_tab[7] = TO - 1;
    clear_mon();
    pulse_start(1'b1);
    check("t6_err_cleared", 32'(err), 0);
    wait_done("t6");
    check_run("t6");
    check("t6_lut7", 32'(wr_data_q.size() > 7 ? wr_data_q[7] : 8'hxx), 32'(qfun(cdf_mem[7])));
    check("t6_err", 32'(err), 0);

    // One-cycle reset while bin 40 is in RUN, then a full rerun.
    fill(1, 2, 5);
    clear_mon();
    pulse_start(1'b1);
    begin
      int n = 0;
      while (!(div_en && cur_bin == 40) && n < 5000) begin
        @(negedge clk);
        n++;
      end
      check("t5_reach_bin40", 32'(n < 5000), 32'd1);
    end
    reset = 1'b0;
    @(negedge clk);
    check_idle("t5_after_reset");
    reset = 1'b1;
    strobes = 0;
    repeat (10) @(negedge clk);
    check("t5_no_strobes", 32'(strobes), 0);
    check("t5_idle_busy", 32'(busy), 0);
    clear_mon();
    pulse_start(1'b1);
    wait_done("t5");
    check_run("t5");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
